// File: rtl/instr_encoder.sv
// Packs R/I/Memory/Branch field bundles into 9-bit instruction words, buffers
// them in a small FIFO and streams them into IMEM with an auto-incrementing address.
module instr_encoder #(
  parameter int ADDR_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        instr_type,
  input  logic [2:0]        alu_func,
  input  logic [1:0]        src_reg1,
  input  logic [1:0]        src_reg2,
  input  logic [1:0]        dest_reg,
  input  logic [4:0]        immediate,
  input  logic              mem_load,
  input  logic [1:0]        mem_data_reg,
  input  logic [1:0]        mem_addr_reg,
  input  logic              done_flag,
  input  logic [1:0]        branch_reg,
  input  logic              im_stall,
  output logic              im_wr_en,
  output logic [ADDR_W-1:0] im_addr,
  output logic [8:0]        im_wr_data,
  output logic              prog_done,
  output logic              err_flag,
  output logic [7:0]        err_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] TYPE_R   = 2'b00;
  localparam logic [1:0] TYPE_I   = 2'b01;
  localparam logic [1:0] TYPE_MEM = 2'b10;
  localparam logic [1:0] TYPE_BR  = 2'b11;

  logic [8:0]      enc_word;
  logic            illegal;
  logic            accept;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic            halt;
  logic [ADDR_W:0] accepted_legal;

  logic [8:0]      fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]   fifo_rd_ptr;
  logic [PW-1:0]   fifo_wr_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [ADDR_W-1:0] wr_ptr;

  always_comb begin
    enc_word = '0;
    case (instr_type)
      TYPE_R:   enc_word = {TYPE_R, alu_func, src_reg1[0], src_reg2[0], dest_reg};
      TYPE_I:   enc_word = {TYPE_I, dest_reg, immediate};
      TYPE_MEM: enc_word = {TYPE_MEM, mem_load, mem_data_reg, mem_addr_reg, 2'b00};
      TYPE_BR:  enc_word = {TYPE_BR, done_flag, src_reg1, src_reg2, branch_reg};
      default:  enc_word = '0;
    endcase
  end

  // R-type only carries the low bit of each source register in the word
  assign illegal    = (instr_type == TYPE_R) && (src_reg1[1] || src_reg2[1]);

  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign in_ready   = !reset && !fifo_full && !halt && !accepted_legal[ADDR_W];
  assign accept     = in_valid && in_ready;
  assign push       = accept && !illegal;
  assign pop        = !fifo_empty && !im_stall;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[fifo_wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_rd_ptr    <= '0;
      fifo_wr_ptr    <= '0;
      fifo_cnt       <= '0;
      accepted_legal <= '0;
      halt           <= 1'b0;
    end else begin
      if (push) begin
        fifo_wr_ptr    <= fifo_wr_ptr + PW'(1);
        accepted_legal <= accepted_legal + (ADDR_W+1)'(1);
        if (instr_type == TYPE_BR && done_flag) halt <= 1'b1;
      end
      if (pop) fifo_rd_ptr <= fifo_rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_wr_en   <= 1'b0;
      im_addr    <= '0;
      im_wr_data <= '0;
      wr_ptr     <= '0;
    end else if (pop) begin
      im_wr_en   <= 1'b1;
      im_addr    <= wr_ptr;
      im_wr_data <= fifo_mem[fifo_rd_ptr];
      wr_ptr     <= wr_ptr + ADDR_W'(1);
    end else begin
      im_wr_en   <= 1'b0;
    end
  end

  // prog_done follows the actual IMEM write of the terminating branch
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_done <= 1'b0;
      err_flag  <= 1'b0;
      err_count <= '0;
    end else begin
      if (im_wr_en && im_wr_data[8:6] == 3'b111) prog_done <= 1'b1;
      if (accept && illegal) begin
        err_flag <= 1'b1;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table-driven encoding stream plus hand-written
// sequences for illegal bundles, stall, done-branch halt, capacity and mid-stream reset.
module tb_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, im_stall;
  logic [1:0] instr_type, src_reg1, src_reg2, dest_reg, mem_data_reg, mem_addr_reg, branch_reg;
  logic [2:0] alu_func;
  logic [4:0] immediate;
  logic       mem_load, done_flag;

  logic       in_ready, im_wr_en, prog_done, err_flag;
  logic [7:0] im_addr, err_count;
  logic [8:0] im_wr_data;

  logic       in_ready2, im_wr_en2, prog_done2, err_flag2;
  logic [1:0] im_addr2;
  logic [7:0] err_count2;
  logic [8:0] im_wr_data2;

  instr_encoder #(.ADDR_W(8), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instr_type(instr_type), .alu_func(alu_func), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dest_reg(dest_reg), .immediate(immediate), .mem_load(mem_load),
    .mem_data_reg(mem_data_reg), .mem_addr_reg(mem_addr_reg), .done_flag(done_flag),
    .branch_reg(branch_reg), .im_stall(im_stall), .im_wr_en(im_wr_en), .im_addr(im_addr),
    .im_wr_data(im_wr_data), .prog_done(prog_done), .err_flag(err_flag), .err_count(err_count)
  );

  instr_encoder #(.ADDR_W(2), .FIFO_DEPTH(4)) u_cap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .instr_type(instr_type), .alu_func(alu_func), .src_reg1(src_reg1), .src_reg2(src_reg2),
    .dest_reg(dest_reg), .immediate(immediate), .mem_load(mem_load),
    .mem_data_reg(mem_data_reg), .mem_addr_reg(mem_addr_reg), .done_flag(done_flag),
    .branch_reg(branch_reg), .im_stall(im_stall), .im_wr_en(im_wr_en2), .im_addr(im_addr2),
    .im_wr_data(im_wr_data2), .prog_done(prog_done2), .err_flag(err_flag2), .err_count(err_count2)
  );

  typedef struct {
    logic [1:0] t;
    logic [2:0] alu;
    logic [1:0] s1, s2, d;
    logic [4:0] imm;
    logic       ld;
    logic [1:0] md, ma;
    logic       dn;
    logic [1:0] br;
    logic [8:0] exp;
  } vec_t;

  typedef struct {
    int         cyc;
    logic [7:0] addr;
    logic [8:0] data;
  } wr_t;

  vec_t vecs[8];
  vec_t v_bdone, v_illegal;
  wr_t  wq[$];
  wr_t  wq2[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic [1:0] t, logic [2:0] alu, logic [1:0] s1, logic [1:0] s2,
                              logic [1:0] d, logic [4:0] imm, logic ld, logic [1:0] md,
                              logic [1:0] ma, logic dn, logic [1:0] br, logic [8:0] exp);
    vec_t v;
    v.t = t; v.alu = alu; v.s1 = s1; v.s2 = s2; v.d = d; v.imm = imm;
    v.ld = ld; v.md = md; v.ma = ma; v.dn = dn; v.br = br; v.exp = exp;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (im_wr_en)  wq.push_back('{cyc, im_addr, im_wr_data});
    if (im_wr_en2) wq2.push_back('{cyc, {6'b0, im_addr2}, im_wr_data2});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Fields the selected type does not use are driven with noise.
  task automatic drive(input vec_t v);
    instr_type = v.t; alu_func = v.alu; src_reg1 = v.s1; src_reg2 = v.s2; dest_reg = v.d;
    immediate = v.imm; mem_load = v.ld; mem_data_reg = v.md; mem_addr_reg = v.ma;
    done_flag = v.dn; branch_reg = v.br;
    case (v.t)
      2'b00: begin
        immediate = 5'($urandom); mem_load = 1'($urandom); mem_data_reg = 2'($urandom);
        mem_addr_reg = 2'($urandom); done_flag = 1'($urandom); branch_reg = 2'($urandom);
      end
      2'b01: begin
        alu_func = 3'($urandom); src_reg1 = 2'($urandom); src_reg2 = 2'($urandom);
        mem_load = 1'($urandom); mem_data_reg = 2'($urandom); mem_addr_reg = 2'($urandom);
        done_flag = 1'($urandom); branch_reg = 2'($urandom);
      end
      2'b10: begin
        alu_func = 3'($urandom); src_reg1 = 2'($urandom); src_reg2 = 2'($urandom);
        dest_reg = 2'($urandom); immediate = 5'($urandom); done_flag = 1'($urandom);
        branch_reg = 2'($urandom);
      end
      default: begin
        alu_func = 3'($urandom); dest_reg = 2'($urandom); immediate = 5'($urandom);
        mem_load = 1'($urandom); mem_data_reg = 2'($urandom); mem_addr_reg = 2'($urandom);
      end
    endcase
    in_valid = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; im_stall = 1'b0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", im_wr_en, 0);
    chk("rst_addr", im_addr, 0);
    chk("rst_data", im_wr_data, 0);
    chk("rst_prog_done", prog_done, 0);
    chk("rst_err_flag", err_flag, 0);
    chk("rst_err_count", err_count, 0);
    reset = 1'b0;
    #1;
    wq.delete();
    wq2.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    logic r;

    vecs[0] = mk(2'b00, 3'b010, 2'd1, 2'd0, 2'd3, 5'h00, 0, 2'd0, 2'd0, 0, 2'd0, 9'b000101011);
    vecs[1] = mk(2'b01, 3'b000, 2'd0, 2'd0, 2'd2, 5'h15, 0, 2'd0, 2'd0, 0, 2'd0, 9'b011010101);
    vecs[2] = mk(2'b10, 3'b000, 2'd0, 2'd0, 2'd0, 5'h00, 1, 2'd1, 2'd2, 0, 2'd0, 9'b101011000);
    vecs[3] = mk(2'b11, 3'b000, 2'd3, 2'd1, 2'd0, 5'h00, 0, 2'd0, 2'd0, 0, 2'd2, 9'b110110110);
    vecs[4] = mk(2'b00, 3'b111, 2'd0, 2'd1, 2'd0, 5'h00, 0, 2'd0, 2'd0, 0, 2'd0, 9'b001110100);
    vecs[5] = mk(2'b01, 3'b000, 2'd0, 2'd0, 2'd1, 5'h00, 0, 2'd0, 2'd0, 0, 2'd0, 9'b010100000);
    vecs[6] = mk(2'b10, 3'b000, 2'd0, 2'd0, 2'd0, 5'h00, 0, 2'd3, 2'd0, 0, 2'd0, 9'b100110000);
    vecs[7] = mk(2'b11, 3'b000, 2'd0, 2'd2, 2'd0, 5'h00, 0, 2'd0, 2'd0, 0, 2'd1, 9'b110001001);
    v_bdone   = mk(2'b11, 3'b000, 2'd1, 2'd2, 2'd0, 5'h00, 0, 2'd0, 2'd0, 1, 2'd3, 9'b111011011);
    v_illegal = mk(2'b00, 3'b001, 2'd2, 2'd0, 2'd1, 5'h00, 0, 2'd0, 2'd0, 0, 2'd0, 9'b000000000);

    reset = 1'b1; in_valid = 1'b0; im_stall = 1'b0;
    drive(vecs[0]);
    in_valid = 1'b0;

    // single R add: latency one edge after accept
    do_reset();
    drive(vecs[0]);
    chk("radd_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    chk("radd_no_early_wr", im_wr_en, 0);
    step();
    chk("radd_wr_en", im_wr_en, 1);
    chk("radd_addr", im_addr, 0);
    chk("radd_data", im_wr_data, 9'b000101011);
    step();
    chk("radd_wr_en_pulse", im_wr_en, 0);

    // table stream, back to back
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      chk("tbl_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();
    chk("tbl_count", wq.size(), 8);
    if (wq.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        chk("tbl_addr", wq[i].addr, i);
        chk("tbl_data", wq[i].data, vecs[i].exp);
        chk("tbl_consecutive", wq[i].cyc - wq[0].cyc, i);
      end
    end

    // illegal R between two legal words, then error-count saturation
    do_reset();
    drive(vecs[4]);
    step();
    drive(v_illegal);
    chk("ill_ready", in_ready, 1);
    step();
    drive(vecs[5]);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    chk("ill_err_flag", err_flag, 1);
    chk("ill_err_count", err_count, 1);
    chk("ill_wr_count", wq.size(), 2);
    if (wq.size() == 2) begin
      chk("ill_addr0", wq[0].addr, 0);
      chk("ill_data0", wq[0].data, vecs[4].exp);
      chk("ill_addr1", wq[1].addr, 1);
      chk("ill_data1", wq[1].data, vecs[5].exp);
    end
    drive(v_illegal);
    src_reg1 = 2'd0; src_reg2 = 2'd2;
    step();
    in_valid = 1'b0;
    step();
    chk("ill_src2_count", err_count, 2);
    drive(v_illegal);
    repeat (300) step();
    in_valid = 1'b0;
    step();
    chk("ill_saturate", err_count, 255);
    chk("ill_no_writes", wq.size(), 2);

    // IMEM stall with in_valid held
    do_reset();
    im_stall = 1'b1;
    acc = 0;
    instr_type = 2'b01; dest_reg = 2'd1; immediate = 5'd0; in_valid = 1'b1;
    repeat (10) begin
      r = in_ready;
      step();
      if (r) begin
        acc++;
        immediate = 5'(acc);
      end
    end
    chk("stall_accepts", acc, 4);
    chk("stall_ready_low", in_ready, 0);
    chk("stall_no_writes", wq.size(), 0);
    in_valid = 1'b0;
    im_stall = 1'b0;
    step();
    chk("stall_first_wr_en", im_wr_en, 1);
    chk("stall_first_addr", im_addr, 0);
    chk("stall_first_data", im_wr_data, 9'b010100000);
    repeat (4) step();
    chk("stall_wr_count", wq.size(), 4);
    if (wq.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("stall_addr", wq[i].addr, i);
        chk("stall_data", wq[i].data, 9'b010100000 | 9'(i));
        chk("stall_consecutive", wq[i].cyc - wq[0].cyc, i);
      end
    end

    // done branch halts intake
    do_reset();
    drive(vecs[1]);
    step();
    drive(v_bdone);
    step();
    drive(vecs[2]);
    chk("done_ready_low", in_ready, 0);
    step();
    chk("done_wr_en", im_wr_en, 1);
    chk("done_addr", im_addr, 1);
    chk("done_data", im_wr_data, 9'b111011011);
    chk("done_pd_not_yet", prog_done, 0);
    step();
    chk("done_prog_done", prog_done, 1);
    chk("done_wr_en_off", im_wr_en, 0);
    repeat (4) step();
    chk("done_still_halted", in_ready, 0);
    chk("done_prog_sticky", prog_done, 1);
    chk("done_wr_count", wq.size(), 2);
    in_valid = 1'b0;

    // capacity limit on the ADDR_W=2 instance
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(vecs[k]);
      chk("cap_ready", in_ready2, 1);
      step();
    end
    drive(vecs[4]);
    repeat (3) begin
      chk("cap_ready_low", in_ready2, 0);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("cap_wr_count", wq2.size(), 4);
    if (wq2.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("cap_addr", wq2[k].addr, k);
        chk("cap_data", wq2[k].data, vecs[k].exp);
      end
    end

    // reset mid-stream with three words buffered
    do_reset();
    drive(vecs[5]);
    step();
    drive(vecs[6]);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    im_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(vecs[k]);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("mid_pre_count", wq.size(), 2);
    reset = 1'b1;
    im_stall = 1'b0;
    #1;
    chk("mid_ready_in_reset", in_ready, 0);
    step();
    chk("mid_wr_en_off", im_wr_en, 0);
    reset = 1'b0;
    repeat (3) step();
    chk("mid_discarded", wq.size(), 2);
    drive(vecs[7]);
    step();
    in_valid = 1'b0;
    step();
    chk("mid_restart_wr_en", im_wr_en, 1);
    chk("mid_restart_addr", im_addr, 0);
    chk("mid_restart_data", im_wr_data, vecs[7].exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
